// File: rtl/rd_chan_arbiter.sv
// rd_chan_arbiter: four-channel round-robin scheduler sharing one AXI read master.
// Grants one channel at a time, issues its burst command, advances that channel's
// read pointer inside its [beg, end] window and steers read data via ch_grant.
// Optional watchdog: define RD_ARB_TIMEOUT_EN to abort bursts stuck in START/WAIT.
module rd_chan_arbiter #(
   parameter int unsigned AXI_WIDTH   = 64,
   parameter int unsigned ADDR_WIDTH  = 30,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_mem_enable,
   input  logic [3:0]            ch_req,
   input  logic [ADDR_WIDTH-1:0] beg_addr0,
   input  logic [ADDR_WIDTH-1:0] beg_addr1,
   input  logic [ADDR_WIDTH-1:0] beg_addr2,
   input  logic [ADDR_WIDTH-1:0] beg_addr3,
   input  logic [ADDR_WIDTH-1:0] end_addr0,
   input  logic [ADDR_WIDTH-1:0] end_addr1,
   input  logic [ADDR_WIDTH-1:0] end_addr2,
   input  logic [ADDR_WIDTH-1:0] end_addr3,
   input  logic [7:0]            burst_len0,
   input  logic [7:0]            burst_len1,
   input  logic [7:0]            burst_len2,
   input  logic [7:0]            burst_len3,
   input  logic                  axi_rd_ready,
   input  logic                  axi_rd_done,
   output logic                  axi_rd_start,
   output logic [ADDR_WIDTH-1:0] axi_rd_addr,
   output logic [7:0]            axi_rd_len,
   output logic [3:0]            ch_grant,
   output logic                  arb_busy,
   output logic                  timeout_err
);

   localparam logic [ADDR_WIDTH:0] BEAT_BYTES = (ADDR_WIDTH+1)'(AXI_WIDTH / 8);
   localparam logic [ADDR_WIDTH:0] ONE        = (ADDR_WIDTH+1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARB,
      ST_START,
      ST_WAIT
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] beg_a [4];
   logic [ADDR_WIDTH-1:0] end_a [4];
   logic [7:0]            len_a [4];

   logic [ADDR_WIDTH-1:0] ptr_q [4];
   logic [ADDR_WIDTH-1:0] ptr_d [4];
   logic [1:0]            last_q, last_d;
   logic [1:0]            win_q, win_d;
   logic [3:0]            grant_q, grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [ADDR_WIDTH-1:0] wbeg_q, wbeg_d;
   logic [ADDR_WIDTH-1:0] wend_q, wend_d;
   logic                  busy_q, busy_d;
   logic                  start_q, start_d;

   logic                  req_any;
   logic [1:0]            pick;
   logic [1:0]            cand;
   logic [ADDR_WIDTH:0]   bytes;
   logic [ADDR_WIDTH:0]   nxt;
   logic [ADDR_WIDTH:0]   tail;
   logic                  wrap;
   logic                  tmo_hit;

   assign beg_a[0] = beg_addr0;
   assign beg_a[1] = beg_addr1;
   assign beg_a[2] = beg_addr2;
   assign beg_a[3] = beg_addr3;
   assign end_a[0] = end_addr0;
   assign end_a[1] = end_addr1;
   assign end_a[2] = end_addr2;
   assign end_a[3] = end_addr3;
   assign len_a[0] = burst_len0;
   assign len_a[1] = burst_len1;
   assign len_a[2] = burst_len2;
   assign len_a[3] = burst_len3;

`ifdef RD_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          tmo_err_q, tmo_err_d;
   logic          in_burst_q, in_burst_d;

   // Watchdog: counts cycles spent in START+WAIT, restarts whenever that span is left
   always_comb begin
      in_burst_q = (state_q == ST_START) || (state_q == ST_WAIT);
      in_burst_d = (state_d == ST_START) || (state_d == ST_WAIT);
      tmo_hit    = in_burst_q && (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));
      tmo_cnt_d  = (in_burst_q && in_burst_d) ? tmo_cnt_q + CW'(1) : '0;
      tmo_err_d  = tmo_err_q | tmo_hit;
   end

   // Watchdog registers; the error flag stays set until reset
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign timeout_err = tmo_err_q;
`else
   // Timeout limit only matters when the watchdog is built in
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
   assign tmo_hit            = 1'b0;
   assign timeout_err        = 1'b0;
`endif

   // Round-robin scan: first requesting channel after the last granted one wins
   always_comb begin
      req_any = 1'b0;
      pick    = 2'd0;
      cand    = 2'd0;
      for (int unsigned k = 1; k <= 4; k++) begin
         cand = last_q + k[1:0];
         if (!req_any && ch_req[cand]) begin
            req_any = 1'b1;
            pick    = cand;
         end
      end
   end

   // Next read pointer for the granted channel, wrapping when the next burst would overrun the window
   always_comb begin
      bytes = ((ADDR_WIDTH+1)'(len_q) + ONE) * BEAT_BYTES;
      nxt   = {1'b0, ptr_q[win_q]} + bytes;
      tail  = nxt + bytes - ONE;
      wrap  = tail > {1'b0, wend_q};
   end

   // State register plus all registered outputs and per-channel pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= 2'd3;
         win_q   <= 2'd0;
         grant_q <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         wbeg_q  <= '0;
         wend_q  <= '0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) ptr_q[i] <= beg_a[i];
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         win_q   <= win_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         wbeg_q  <= wbeg_d;
         wend_q  <= wend_d;
         busy_q  <= busy_d;
         start_q <= start_d;
         for (int unsigned i = 0; i < 4; i++) ptr_q[i] <= ptr_d[i];
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (rd_mem_enable) state_d = ST_ARB;
         ST_ARB: begin
            if (!rd_mem_enable)   state_d = ST_IDLE;
            else if (req_any)     state_d = ST_START;
         end
         ST_START: begin
            if (tmo_hit)          state_d = ST_ARB;
            else if (axi_rd_ready) state_d = ST_WAIT;
         end
         ST_WAIT:  if (axi_rd_done || tmo_hit) state_d = ST_ARB;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output/datapath logic: grant capture, command strobe, pointer advance or reload
   always_comb begin
      last_d  = last_q;
      win_d   = win_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      len_d   = len_q;
      wbeg_d  = wbeg_q;
      wend_d  = wend_q;
      busy_d  = busy_q;
      start_d = 1'b0;
      for (int unsigned i = 0; i < 4; i++) ptr_d[i] = ptr_q[i];
      case (state_q)
         ST_IDLE: begin
            if (!rd_mem_enable) begin
               for (int unsigned i = 0; i < 4; i++) ptr_d[i] = beg_a[i];
            end
         end
         ST_ARB: begin
            if (rd_mem_enable && req_any) begin
               grant_d = 4'b0001 << pick;
               win_d   = pick;
               addr_d  = ptr_q[pick];
               len_d   = len_a[pick];
               wbeg_d  = beg_a[pick];
               wend_d  = end_a[pick];
               busy_d  = 1'b1;
            end
         end
         ST_START: begin
            if (tmo_hit) begin
               grant_d = '0;
               busy_d  = 1'b0;
               last_d  = win_q;
            end else if (axi_rd_ready) begin
               start_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (axi_rd_done) begin
               ptr_d[win_q] = wrap ? wbeg_q : nxt[ADDR_WIDTH-1:0];
               last_d       = win_q;
               grant_d      = '0;
               busy_d       = 1'b0;
            end else if (tmo_hit) begin
               grant_d = '0;
               busy_d  = 1'b0;
               last_d  = win_q;
            end
         end
         default: ;
      endcase
   end

   assign axi_rd_start = start_q;
   assign axi_rd_addr  = addr_q;
   assign axi_rd_len   = len_q;
   assign ch_grant     = grant_q;
   assign arb_busy     = busy_q;

endmodule

// File: tb/tb_rd_chan_arbiter.sv
// Self-checking bench for rd_chan_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level reference model.
module tb_rd_chan_arbiter;

   localparam int AW  = 64;
   localparam int ADW = 30;
   localparam int TMO = 16;

   logic           clk = 1'b0;
   logic           rst, en, ready, done;
   logic [3:0]     req;
   logic [ADW-1:0] beg [4];
   logic [ADW-1:0] endw [4];
   logic [7:0]     bl [4];

   logic           axi_rd_start;
   logic [ADW-1:0] axi_rd_addr;
   logic [7:0]     axi_rd_len;
   logic [3:0]     ch_grant;
   logic           arb_busy;
   logic           timeout_err;

   rd_chan_arbiter #(.AXI_WIDTH(AW), .ADDR_WIDTH(ADW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .rd_mem_enable(en), .ch_req(req),
      .beg_addr0(beg[0]), .beg_addr1(beg[1]), .beg_addr2(beg[2]), .beg_addr3(beg[3]),
      .end_addr0(endw[0]), .end_addr1(endw[1]), .end_addr2(endw[2]), .end_addr3(endw[3]),
      .burst_len0(bl[0]), .burst_len1(bl[1]), .burst_len2(bl[2]), .burst_len3(bl[3]),
      .axi_rd_ready(ready), .axi_rd_done(done),
      .axi_rd_start(axi_rd_start), .axi_rd_addr(axi_rd_addr), .axi_rd_len(axi_rd_len),
      .ch_grant(ch_grant), .arb_busy(arb_busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   bit          m_ok = 0;
   bit          m_run, m_active, m_issued, m_exp;
   int          m_ch, m_last, m_cnt, m_c;
   longint      m_ptr [4];
   longint      m_wbeg, m_wend, m_bytes, m_nxt;
   logic [3:0]  e_grant;
   logic [ADW-1:0] e_addr;
   logic [7:0]  e_len;
   logic        e_busy, e_start, e_tmo;

   always @(posedge clk) begin
      e_start = 1'b0;
      if (rst) begin
         m_ok = 1; m_run = 0; m_active = 0; m_issued = 0; m_last = 3; m_cnt = 0;
         for (int i = 0; i < 4; i++) m_ptr[i] = beg[i];
         e_grant = '0; e_addr = '0; e_len = '0; e_busy = 0; e_tmo = 0;
      end else if (m_ok) begin
         if (!m_active) begin
            if (!m_run) begin
               if (!en) for (int i = 0; i < 4; i++) m_ptr[i] = beg[i];
               else m_run = 1;
            end else if (!en) begin
               m_run = 0;
            end else begin
               for (int k = 1; k <= 4; k++) begin
                  m_c = (m_last + k) % 4;
                  if (!m_active && req[m_c]) begin m_active = 1; m_ch = m_c; end
               end
               if (m_active) begin
                  m_issued = 0; m_cnt = 0;
                  e_grant = 4'(1 << m_ch); e_addr = ADW'(m_ptr[m_ch]); e_len = bl[m_ch];
                  m_wbeg = beg[m_ch]; m_wend = endw[m_ch]; e_busy = 1;
               end
            end
         end else begin
            m_exp = 0;
`ifdef RD_ARB_TIMEOUT_EN
            m_exp = (m_cnt == TMO - 1);
            m_cnt++;
`endif
            if (!m_issued && m_exp) begin
               e_tmo = 1; e_grant = '0; e_busy = 0; m_last = m_ch; m_active = 0;
            end else if (!m_issued) begin
               if (ready) begin e_start = 1; m_issued = 1; end
            end else if (done) begin
               m_bytes = (longint'(e_len) + 1) * (AW / 8);
               m_nxt   = m_ptr[m_ch] + m_bytes;
               m_ptr[m_ch] = (m_nxt + m_bytes - 1 > m_wend) ? m_wbeg : m_nxt;
               m_last = m_ch; e_grant = '0; e_busy = 0; m_active = 0;
            end else if (m_exp) begin
               e_tmo = 1; e_grant = '0; e_busy = 0; m_last = m_ch; m_active = 0;
            end
         end
      end
   end

   // Per-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (m_ok) begin
         check("mdl_start", axi_rd_start, e_start);
         check("mdl_grant", ch_grant, e_grant);
         check("mdl_addr",  axi_rd_addr, e_addr);
         check("mdl_len",   axi_rd_len, e_len);
         check("mdl_busy",  arb_busy, e_busy);
         check("mdl_tmo",   timeout_err, e_tmo);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input string nm, input int lim);
      bit got = 0;
      for (int i = 0; i < lim && !got; i++) begin
         @(negedge clk);
         if (axi_rd_start === 1'b1) got = 1;
      end
      total++;
      if (!got) begin bad++; $display("FAIL %s: no axi_rd_start within %0d cycles", nm, lim); end
   endtask

   task automatic wait_grant(input string nm, input logic [3:0] g, input int lim);
      bit got = 0;
      for (int i = 0; i < lim && !got; i++) begin
         @(negedge clk);
         if (ch_grant === g) got = 1;
      end
      total++;
      if (!got) begin bad++; $display("FAIL %s: grant=%b never reached required %b", nm, ch_grant, g); end
   endtask

   task automatic pulse_done();
      step(3); done = 1; step(1); done = 0;
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "_start"}, axi_rd_start, 0);
      check({nm, "_addr"},  axi_rd_addr, 0);
      check({nm, "_len"},   axi_rd_len, 0);
      check({nm, "_grant"}, ch_grant, 0);
      check({nm, "_busy"},  arb_busy, 0);
      check({nm, "_tmo"},   timeout_err, 0);
   endtask

   int exp_g [6] = '{1, 2, 4, 8, 1, 2};
   int exp_a [6] = '{0, 1024, 2048, 3072, 128, 1152};
   int n_st;

   initial begin
      rst = 1; en = 0; req = '0; ready = 1; done = 0;
      for (int i = 0; i < 4; i++) begin
         beg[i] = ADW'(i * 1024); endw[i] = ADW'(i * 1024 + 1023); bl[i] = 8'd15;
      end
      step(2);
      check_reset_outputs("reset");

      // Single channel: 128-byte steps through 0..896 then wrap
      rst = 0; en = 1; req = 4'b0001;
      for (int b = 0; b < 9; b++) begin
         wait_start("t1_start", 20);
         check("t1_addr", axi_rd_addr, (b == 8) ? 0 : b * 128);
         check("t1_len", axi_rd_len, 15);
         check("t1_grant", ch_grant, 4'b0001);
         pulse_done();
      end

      // All channels requesting: round-robin order and per-window addresses
      rst = 1; step(1); rst = 0; req = 4'b1111;
      @(negedge clk);
      check_reset_outputs("t2_rst");
      for (int b = 0; b < 6; b++) begin
         wait_start("t2_start", 20);
         check("t2_grant", ch_grant, exp_g[b]);
         check("t2_addr", axi_rd_addr, exp_a[b]);
         if (b == 5) begin step(1); req = '0; end
         pulse_done();
      end

      // Ready held low: grant persists, no strobe until ready rises
      rst = 1; step(1); rst = 0; req = 4'b0100; ready = 0;
      wait_grant("t3_grant", 4'b0100, 20);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_hold_grant", ch_grant, 4'b0100);
         check("t3_no_start", axi_rd_start, 0);
      end
      step(1); ready = 1;
      @(negedge clk); check("t3_start_pre", axi_rd_start, 0);
      @(negedge clk); check("t3_start_pulse", axi_rd_start, 1);
      check("t3_addr", axi_rd_addr, 2048);
      @(negedge clk); check("t3_start_post", axi_rd_start, 0);
      step(1); req = '0;
      pulse_done();

      // Enable dropped during WAIT of channel 1
      rst = 1; step(1); rst = 0; req = 4'b0010;
      wait_start("t4_start", 20);
      check("t4_addr", axi_rd_addr, 1024);
      step(1); en = 0;
      step(2); done = 1; step(1); done = 0;
      n_st = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (axi_rd_start === 1'b1) n_st++;
      end
      check("t4_no_start", n_st, 0);
      check("t4_idle_grant", ch_grant, 0);
      check("t4_idle_busy", arb_busy, 0);
      step(1); en = 1;
      wait_start("t4_restart", 20);
      check("t4_reload_addr", axi_rd_addr, 1024);
      step(1); req = '0;
      pulse_done();

      // Reset during WAIT abandons the burst; stray done afterwards is ignored
      rst = 1; step(1); rst = 0; req = 4'b0001;
      wait_start("t5_first", 20);
      pulse_done();
      wait_start("t5_second", 20);
      check("t5_addr2", axi_rd_addr, 128);
      step(1); rst = 1; step(1); rst = 0; en = 0; req = '0;
      @(negedge clk);
      check_reset_outputs("t5_rst");
      step(1); done = 1; step(1); done = 0;
      step(2); en = 1; req = 4'b0001;
      wait_start("t5_after", 20);
      check("t5_addr_beg", axi_rd_addr, 0);
      step(1); req = '0;
      pulse_done();

`ifdef RD_ARB_TIMEOUT_EN
      // Watchdog: no done, abort after TMO cycles, next requester served
      rst = 1; step(1); rst = 0; req = 4'b0011; ready = 1;
      wait_grant("t6_grant0", 4'b0001, 20);
      for (int j = 1; j <= TMO; j++) begin
         @(negedge clk);
         if (j < TMO) check("t6_tmo_low", timeout_err, 0);
         else begin
            check("t6_tmo_set", timeout_err, 1);
            check("t6_grant_clr", ch_grant, 0);
         end
      end
      @(negedge clk);
      check("t6_next_grant", ch_grant, 4'b0010);
      step(1); req = '0;
      pulse_done();
      rst = 1; step(1); rst = 0;
`endif

      // Randomized traffic checked by the model every cycle
      for (int c = 0; c < 4000; c++) begin
         step(1);
         rst   = ($urandom_range(0, 299) == 0);
         en    = ($urandom_range(0, 19) != 0);
         req   = 4'($urandom);
         ready = ($urandom_range(0, 3) != 0);
         done  = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0) begin
            for (int i = 0; i < 4; i++) begin
               beg[i]  = ADW'(i * 8192 + 8 * $urandom_range(0, 100));
               endw[i] = beg[i] + ADW'($urandom_range(100, 4000));
               bl[i]   = 8'($urandom_range(0, 15));
            end
         end
      end
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
